sel_mux_rr: RTL and testbench
=============================

# sel_mux_rr

Parametrised N-channel, W-bit registered channel selector: the successor to the fixed 8:1 single-bit combinational multiplexor. Each input lane has a valid/ready handshake. The block picks one lane per cycle, either by an explicit select or by round-robin scan, and presents the chosen word on a registered output with its own valid/ready handshake. It sits between parallel producer lanes and a single downstream consumer.

## Interface
Parameters:
- `W`, 8, data width per lane (≥1)
- `N`, 8, number of input lanes (2..64, need not be a power of two)
- `SW`, `$clog2(N)`, select and channel-index width (derived)

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in N*W: lane k occupies bits [k*W+W-1 : k*W]
- `in_valid` in N: per-lane valid
- `in_ready` out N: per-lane ready; at most one bit set per cycle
- `mode` in 1: 0 = directed (use `sel`), 1 = round-robin
- `sel` in SW: lane index used in directed mode
- `out_data` out W: registered selected word
- `out_chan` out SW: lane index that `out_data` came from
- `out_valid` out 1: output register holds a word
- `out_ready` in 1: consumer accepts the word

## Operation
- Output register (`out_data`, `out_chan`, `out_valid`) is one entry.
  - `load_en = !out_valid || out_ready`.
- Grant logic is combinational in the current cycle. It produces `gnt_vld` and `gnt` (SW bits).
- Directed mode (`mode`=0):
  - `gnt = sel`.
  - `gnt_vld = load_en && sel < N && in_valid[sel]`.
  - A `sel` value ≥ N never grants.
- Round-robin mode (`mode`=1):
  - Scan from pointer `ptr` upward, wrapping N-1→0.
  - `gnt` = first lane with `in_valid` set.
  - `gnt_vld = load_en && |in_valid`.
- `in_ready[gnt] = load_en`. The bit is asserted whenever `load_en` is true, and only when that lane is the current pick, i.e. `sel` < N in directed mode or `|in_valid` in round-robin mode. All other `in_ready` bits are 0.
  - A lane transfers when its `in_valid && in_ready` are both set.
- On `gnt_vld`:
  - `out_data` ← lane `gnt` word, `out_chan` ← `gnt`, `out_valid` ← 1.
- If `load_en` is true and there is no grant: `out_valid` ← 0. `out_data` and `out_chan` hold their values.
- If `load_en` is false: all output registers hold.
- Pointer `ptr` (SW bits):
  - On a round-robin grant: `ptr` ← (`gnt`+1) mod N. This wraps at N, not at 2^SW.
  - Unchanged in directed mode and on cycles with no grant.
  - `mode` toggling does not clear `ptr`.
- Arithmetic: `ptr` increment and compare are done at SW+1 bits, so values never alias when N is not a power of two.

## Timing
- Reset (`rst`=1 at an edge): `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0.
  - While `rst` is high, all `in_ready`=0.
  - Reset mid-transfer discards the held word. No lane transfer is counted in a reset cycle.
- Latency: an input accepted at edge t appears on `out_*` after edge t, i.e. one cycle.
- Throughput: one word per cycle while `out_ready`=1.
- Backpressure (`out_valid`=1, `out_ready`=0): all `in_ready`=0, and `out_data`/`out_chan` are stable until accepted.
- Simultaneous accept and load (`out_valid && out_ready && gnt_vld`): the new word replaces the old word in the same edge, with no bubble.
- `in_ready` depends combinationally on `out_ready`, `mode`, `sel` and `in_valid`. `out_*` are purely registered.
- `mode` and `sel` are sampled every cycle; a change takes effect on the same cycle's grant.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with all lanes valid → `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0; after release, the first round-robin grant is lane 0.
- Directed: `mode`=0, `sel`=3, lane3=0xA5, all lanes valid, `out_ready`=1 → `in_ready`=8'b0000_1000; next cycle `out_data`=0xA5, `out_chan`=3; `ptr` stays 0.
- Round-robin fairness: `mode`=1, all 8 lanes valid, lane k data = 0x10+k, `out_ready`=1 for 10 cycles → `out_chan` sequence 0,1,…,7,0,1 with matching data; one word per cycle.
- Sparse round-robin with wrap: only lanes 2 and 5 valid, `ptr`=6 → grants 2, 5, 2, 5; with N=5, lanes 4 and 0 valid → grants 4, 0, 4 (wrap at 5).
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1 with `out_data`=0x3C → data and channel stable, `in_ready`=0, `ptr` frozen; raising `out_ready` loads the next lane in the same edge.
- Out-of-range and reset mid-flight: N=5, `mode`=0, `sel`=6 → no `in_ready`, `out_valid` drops to 0 after the pending word is taken; asserting `rst` while `out_valid`=1 → `out_valid`=0 on the next edge.

Source files
------------

// File: rtl/sel_mux_rr.sv
// N-lane, W-bit channel selector with a one-entry registered output.
// Each cycle it picks one lane, either by explicit select or by a round-robin scan.
module sel_mux_rr #(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int          NP    = 1 << SW;
    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_pick;
    logic          w_gnt_vld;
    logic [SW-1:0] w_gnt;
    logic          w_rr_found;
    logic [SW-1:0] w_rr_gnt;
    logic [SW:0]   w_ptr_inc;
    logic [SW-1:0] w_ptr_next;
    logic [NP-1:0] w_valid_pad;
    logic [W-1:0]  w_lane [N];
    logic [W-1:0]  w_gnt_data;

    // Pad valid to a power-of-two width so any select value indexes in range.
    assign w_valid_pad = NP'(in_valid);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign w_lane[gi] = in_data[gi*W +: W];
        end
    endgenerate

    assign w_load_en = !r_out_valid || out_ready;

    // Scan from r_ptr upward; wrap is done at SW+1 bits against N, not 2^SW.
    always_comb begin
        logic [SW:0] idx;
        idx        = '0;
        w_rr_found = 1'b0;
        w_rr_gnt   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, r_ptr} + (SW+1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!w_rr_found && w_valid_pad[idx[SW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_gnt   = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_gnt  = w_rr_gnt;
            w_pick = w_rr_found;
        end else begin
            w_gnt  = sel;
            w_pick = ({1'b0, sel} < N_EXT);
        end
    end

    // A directed pick may present ready to an idle lane; it only loads if that lane is valid.
    assign w_gnt_vld = w_load_en && w_pick && w_valid_pad[w_gnt];

    always_comb begin
        in_ready = '0;
        if (!rst && w_load_en && w_pick) begin
            in_ready = N'(1) << w_gnt;
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt == SW'(k)) begin
                w_gnt_data = w_lane[k];
            end
        end
    end

    assign w_ptr_inc  = {1'b0, w_gnt} + (SW+1)'(1);
    assign w_ptr_next = (w_ptr_inc >= N_EXT) ? '0 : w_ptr_inc[SW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_chan  <= w_gnt;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_sel_mux_rr.sv
// Bench for sel_mux_rr: an N=8 and an N=5 instance share stimulus and are compared
// every cycle against a lane-level reference model, with directed steps then random traffic.
module tb_sel_mux_rr;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mode;
    logic        out_ready;
    logic [2:0]  sel;
    logic [63:0] in_data;
    logic [7:0]  in_valid;

    logic [7:0]  rdy8;
    logic [4:0]  rdy5;
    logic [7:0]  od8, od5;
    logic [2:0]  oc8, oc5;
    logic        ov8, ov5;

    int checks   = 0;
    int failures = 0;

    // Reference state per instance: 0 -> N=8, 1 -> N=5
    int nl    [2] = '{8, 5};
    bit m_v   [2];
    int m_d   [2];
    int m_c   [2];
    int m_ptr [2];

    sel_mux_rr #(.W(8), .N(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy8),
        .mode(mode), .sel(sel), .out_data(od8), .out_chan(oc8), .out_valid(ov8),
        .out_ready(out_ready)
    );

    sel_mux_rr #(.W(8), .N(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data[39:0]), .in_valid(in_valid[4:0]), .in_ready(rdy5),
        .mode(mode), .sel(sel), .out_data(od5), .out_chan(oc5), .out_valid(ov5),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check in_ready mid-cycle, advance the model at the edge, check outputs after.
    task automatic step();
        int g   [2];
        bit pick[2];
        bit gv  [2];
        bit load[2];
        logic [63:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int n;
            n       = nl[i];
            g[i]    = 0;
            pick[i] = 1'b0;
            load[i] = !m_v[i] || out_ready;
            if (!mode) begin
                g[i]    = int'(sel);
                pick[i] = (g[i] < n);
                gv[i]   = load[i] && pick[i] && in_valid[g[i]];
            end else begin
                for (int k = 0; k < n; k++) begin
                    int idx;
                    idx = (m_ptr[i] + k) % n;
                    if (!pick[i] && in_valid[idx]) begin
                        pick[i] = 1'b1;
                        g[i]    = idx;
                    end
                end
                gv[i] = load[i] && pick[i];
            end
            exp_rdy = (!rst && load[i] && pick[i]) ? (64'd1 << g[i]) : 64'd0;
            chk($sformatf("n%0d.in_ready", n), (i == 0) ? 64'(rdy8) : 64'(rdy5), exp_rdy);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_v[i] = 1'b0; m_d[i] = 0; m_c[i] = 0; m_ptr[i] = 0;
            end else if (load[i]) begin
                if (gv[i]) begin
                    m_v[i] = 1'b1;
                    m_d[i] = int'(in_data[g[i]*8 +: 8]);
                    m_c[i] = g[i];
                    if (mode) m_ptr[i] = (g[i] + 1) % nl[i];
                end else begin
                    m_v[i] = 1'b0;
                end
            end
        end
        #1;
        chk("n8.out_valid", 64'(ov8), 64'(m_v[0]));
        chk("n8.out_data",  64'(od8), 64'(m_d[0]));
        chk("n8.out_chan",  64'(oc8), 64'(m_c[0]));
        chk("n5.out_valid", 64'(ov5), 64'(m_v[1]));
        chk("n5.out_data",  64'(od5), 64'(m_d[1]));
        chk("n5.out_chan",  64'(oc5), 64'(m_c[1]));
    endtask

    task automatic lanes_ramp();
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_d[i] = 0; m_c[i] = 0; m_ptr[i] = 0;
        end

        // Reset with every lane valid
        rst = 1'b1; mode = 1'b1; sel = 3'd0; out_ready = 1'b1; in_valid = 8'hFF;
        lanes_ramp();
        step();
        step();
        chk("reset.valid", 64'(ov8), 64'd0);
        chk("reset.data",  64'(od8), 64'd0);

        // Directed select of lane 3
        rst = 1'b0; mode = 1'b0; sel = 3'd3; in_data[31:24] = 8'hA5;
        step();
        chk("dir.data", 64'(od8), 64'hA5);
        chk("dir.chan", 64'(oc8), 64'd3);

        // Round-robin fairness from ptr 0
        mode = 1'b1; lanes_ramp();
        for (int j = 0; j < 10; j++) begin
            step();
            chk("rr.chan", 64'(oc8), 64'(j % 8));
            chk("rr.data", 64'(od8), 64'(8'h10 + (j % 8)));
        end

        // Sparse round-robin and wrap: park ptr8 at 6, then lanes 2/5, then lanes 0/4
        in_valid = 8'b0010_0000;
        step();
        in_valid = 8'b0010_0100;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("sparse.chan", 64'(oc8), (j % 2 == 0) ? 64'd2 : 64'd5);
        end
        in_valid = 8'b0001_0001;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("wrap5.chan", 64'(oc5), (j % 2 == 0) ? 64'd4 : 64'd0);
        end

        // Backpressure on a held 0x3C word
        in_valid = 8'hFF; in_data = {8{8'h3C}};
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_data  = {$urandom, $urandom};
            in_valid = 8'($urandom);
            step();
            chk("bp.data", 64'(od8), 64'h3C);
        end
        out_ready = 1'b1; in_valid = 8'hFF;
        step();

        // Out-of-range select for N=5: pending word drains, then valid drops
        mode = 1'b0; sel = 3'd6; out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        step();
        chk("oor.valid5", 64'(ov5), 64'd0);

        // Reset while a word is held
        mode = 1'b1; sel = 3'd0;
        step();
        out_ready = 1'b0; rst = 1'b1;
        step();
        chk("midrst.valid", 64'(ov8), 64'd0);
        rst = 1'b0; out_ready = 1'b1;

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
